// File: rtl/vdc_cpuport.sv
// vdc_cpuport: CPU register port of the VDC with a write queue, read-ahead and block fill engine.
// Define VDC_CPUPORT_COPY_EN to build the block-copy states. ADDR_BITS is expected in 9..16.
module vdc_cpuport #(
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned WC_BITS    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           regA,
  input  logic [7:0]           db_in,
  input  logic                 reg_wstb,
  input  logic                 reg_rstb,
  input  logic                 reg_copy,
  input  logic                 reg_rev,
  input  logic                 slot_start,
  input  logic                 slot_end,
  input  logic [7:0]           ram_do,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_di,
  output logic                 ram_rd,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] reg_ua,
  output logic [ADDR_BITS-1:0] reg_ba,
  output logic [WC_BITS-1:0]   reg_wc,
  output logic [7:0]           reg_da,
  output logic                 busy,
  output logic                 ovf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = ADDR_BITS + 8;
  localparam logic [PtrW:0]          PtrOne  = (PtrW+1)'(1);
  localparam logic [PtrW:0]          FullCnt = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0]   AddrOne = ADDR_BITS'(1);
  localparam logic [WC_BITS-1:0]     WcOne   = WC_BITS'(1);

`ifdef VDC_CPUPORT_COPY_EN
  typedef enum logic [2:0] {StIdle, StWrite, StRead, StFill, StCopyRd, StCopyWr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWrite, StRead, StFill} state_e;
`endif

  state_e state_q, state_d;

  logic [ADDR_BITS-1:0] ua_q, ua_d, ba_q, ba_d, ram_addr_q, ram_addr_d;
  logic [WC_BITS-1:0]   wc_q, wc_d, cnt_q, cnt_d;
  logic [7:0]           da_q, da_d, wda_q, wda_d, ram_di_q, ram_di_d;
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d, read_pend_q, read_pend_d, blk_act_q, blk_act_d;
  logic                 ram_rd_q, ram_rd_d, ram_we_q, ram_we_d;

  logic [EntW-1:0]      fifo_mem [FIFO_DEPTH];
  logic                 push;
  logic [EntW-1:0]      push_data;
  logic [EntW-1:0]      head;
  logic [PtrW:0]        fill_lvl;
  logic [ADDR_BITS-1:0] step;

`ifdef VDC_CPUPORT_COPY_EN
  logic                 blk_copy_q, blk_copy_d, have_byte_q, have_byte_d;
  logic [7:0]           cbyte_q, cbyte_d;
`else
  logic                 unused_reg_copy;
  assign unused_reg_copy = reg_copy;
`endif

  assign step = reg_rev ? '1 : AddrOne;

  always_comb begin
    state_d     = state_q;
    ua_d        = ua_q;
    ba_d        = ba_q;
    wc_d        = wc_q;
    cnt_d       = cnt_q;
    da_d        = da_q;
    wda_d       = wda_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    read_pend_d = read_pend_q;
    blk_act_d   = blk_act_q;
    ram_addr_d  = ram_addr_q;
    ram_di_d    = ram_di_q;
    ram_rd_d    = 1'b0;
    ram_we_d    = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    head        = '0;
    fill_lvl    = '0;
`ifdef VDC_CPUPORT_COPY_EN
    blk_copy_d  = blk_copy_q;
    have_byte_d = have_byte_q;
    cbyte_d     = cbyte_q;
`endif

    // Completion of the granted slot; in IDLE a stray slot_end has no effect.
    if (slot_end) begin
      case (state_q)
        StWrite: rd_ptr_d = rd_ptr_q + PtrOne;
        StRead: begin
          da_d        = ram_do;
          read_pend_d = 1'b0;
        end
        StFill: begin
          ua_d  = ua_q + step;
          cnt_d = cnt_q - WcOne;
          if (cnt_q == WcOne) begin
            blk_act_d   = 1'b0;
            read_pend_d = 1'b1;
          end
        end
`ifdef VDC_CPUPORT_COPY_EN
        StCopyRd: begin
          cbyte_d     = ram_do;
          ba_d        = ba_q + step;
          have_byte_d = 1'b1;
        end
        StCopyWr: begin
          ua_d        = ua_q + step;
          cnt_d       = cnt_q - WcOne;
          have_byte_d = 1'b0;
          if (cnt_q == WcOne) begin
            blk_act_d   = 1'b0;
            read_pend_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      state_d = StIdle;
    end

    // Occupancy after any pop this cycle, so a push alongside a pop never overflows.
    fill_lvl = wr_ptr_q - rd_ptr_d;

    if (reg_wstb) begin
      case (regA)
        6'd18: begin
          ua_d[ADDR_BITS-1:8] = db_in[ADDR_BITS-9:0];
          read_pend_d         = 1'b1;
        end
        6'd19: begin
          ua_d[7:0]   = db_in;
          read_pend_d = 1'b1;
        end
        6'd32: ba_d[ADDR_BITS-1:8] = db_in[ADDR_BITS-9:0];
        6'd33: ba_d[7:0] = db_in;
        6'd30: begin
          wc_d      = WC_BITS'(db_in);
          cnt_d     = WC_BITS'(db_in);
          blk_act_d = 1'b1;
`ifdef VDC_CPUPORT_COPY_EN
          blk_copy_d  = reg_copy;
          have_byte_d = 1'b0;
`endif
        end
        6'd31: begin
          if (fill_lvl == FullCnt) begin
            ovf_d = 1'b1;
          end else begin
            push        = 1'b1;
            push_data   = {ua_d, db_in};
            wda_d       = db_in;
            wr_ptr_d    = wr_ptr_q + PtrOne;
            ua_d        = ua_d + AddrOne;
            read_pend_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (reg_rstb && (regA == 6'd31)) begin
      ua_d        = ua_d + AddrOne;
      read_pend_d = 1'b1;
      ovf_d       = 1'b0;
    end

    // Slot arbitration: queued writes, then read-ahead, then the block engine.
    head = fifo_mem[rd_ptr_d[PtrW-1:0]];
    if (slot_start && (state_d == StIdle)) begin
      if (wr_ptr_q != rd_ptr_d) begin
        state_d    = StWrite;
        ram_addr_d = head[EntW-1:8];
        ram_di_d   = head[7:0];
        ram_we_d   = 1'b1;
      end else if (read_pend_d) begin
        state_d    = StRead;
        ram_addr_d = ua_d;
        ram_rd_d   = 1'b1;
      end else if (blk_act_d && !push) begin
`ifdef VDC_CPUPORT_COPY_EN
        if (blk_copy_d && !have_byte_d) begin
          state_d    = StCopyRd;
          ram_addr_d = ba_d;
          ram_rd_d   = 1'b1;
        end else if (blk_copy_d) begin
          state_d    = StCopyWr;
          ram_addr_d = ua_d;
          ram_di_d   = cbyte_d;
          ram_we_d   = 1'b1;
        end else begin
          state_d    = StFill;
          ram_addr_d = ua_d;
          ram_di_d   = wda_d;
          ram_we_d   = 1'b1;
        end
`else
        state_d    = StFill;
        ram_addr_d = ua_d;
        ram_di_d   = wda_d;
        ram_we_d   = 1'b1;
`endif
      end else begin
        ram_addr_d = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ua_q        <= '0;
      ba_q        <= '0;
      wc_q        <= '0;
      cnt_q       <= '0;
      da_q        <= '0;
      wda_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      read_pend_q <= 1'b0;
      blk_act_q   <= 1'b0;
      ram_addr_q  <= '1;
      ram_di_q    <= '0;
      ram_rd_q    <= 1'b0;
      ram_we_q    <= 1'b0;
`ifdef VDC_CPUPORT_COPY_EN
      blk_copy_q  <= 1'b0;
      have_byte_q <= 1'b0;
      cbyte_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ua_q        <= ua_d;
      ba_q        <= ba_d;
      wc_q        <= wc_d;
      cnt_q       <= cnt_d;
      da_q        <= da_d;
      wda_q       <= wda_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      read_pend_q <= read_pend_d;
      blk_act_q   <= blk_act_d;
      ram_addr_q  <= ram_addr_d;
      ram_di_q    <= ram_di_d;
      ram_rd_q    <= ram_rd_d;
      ram_we_q    <= ram_we_d;
`ifdef VDC_CPUPORT_COPY_EN
      blk_copy_q  <= blk_copy_d;
      have_byte_q <= have_byte_d;
      cbyte_q     <= cbyte_d;
`endif
    end
  end

  // Queue storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PtrW-1:0]] <= push_data;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_di   = ram_di_q;
  assign ram_rd   = ram_rd_q;
  assign ram_we   = ram_we_q;
  assign reg_ua   = ua_q;
  assign reg_ba   = ba_q;
  assign reg_wc   = wc_q;
  assign reg_da   = da_q;
  assign ovf      = ovf_q;
  assign busy     = (wr_ptr_q != rd_ptr_q) || read_pend_q || blk_act_q || (state_q != StIdle);

endmodule
